// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by mem_arbiter and rr_picker.
package mem_arb_pkg;

  localparam int LAT_W = 4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-input arbitration picker: round-robin on the pointer, or port 0 first
// when fixed priority is selected. Purely combinational.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  input  logic fixed,
  output logic valid,
  output logic winner
);

  // winner selection; a lone requester wins regardless of the pointer
  always_comb begin
    valid  = req0 | req1;
    winner = PORT_CORE;
    if (req0 && req1) begin
      winner = fixed ? PORT_CORE : ptr;
    end else if (req1) begin
      winner = PORT_DMA;
    end else begin
      winner = PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the core (port 0)
// and the loader/DMA (port 1), with a fixed command-to-response latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] CNT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
  localparam logic             FIXED_L  = (FIXED_PRIO != 0) ? 1'b1 : 1'b0;
  // a single-cycle memory skips WAIT entirely
  localparam arb_state_e       ST_AFTER_GNT = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;

  arb_state_e       state_r, state_nxt_s;
  logic [LAT_W-1:0] cnt_r, cnt_nxt_s;
  logic             owner_r, owner_nxt_s;
  logic             we_r, we_nxt_s;
  logic             ptr_r, ptr_nxt_s;
  logic             valid_s, winner_s, grant_s;

  rr_picker u_picker (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr_r),
    .fixed  (FIXED_L),
    .valid  (valid_s),
    .winner (winner_s)
  );

  // state, latency counter, owner/we latch and priority pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      owner_r <= PORT_CORE;
      we_r    <= 1'b0;
      ptr_r   <= PORT_CORE;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      owner_r <= owner_nxt_s;
      we_r    <= we_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // next-state logic; the counter loads on grant and holds at 1
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    owner_nxt_s = owner_r;
    we_nxt_s    = we_r;
    ptr_nxt_s   = ptr_r;
    grant_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          grant_s     = 1'b1;
          owner_nxt_s = winner_s;
          we_nxt_s    = winner_s ? we1 : we0;
          cnt_nxt_s   = CNT_LOAD;
          ptr_nxt_s   = ~winner_s;
          state_nxt_s = ST_AFTER_GNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // output muxing; everything is forced low while reset is asserted
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    rdata0    = {DATA_W{1'b0}};
    rdata1    = {DATA_W{1'b0}};
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_r != ST_IDLE) | grant_s;
      if (grant_s) begin
        gnt0      = ~winner_s;
        gnt1      = winner_s;
        mem_en    = 1'b1;
        mem_we    = winner_s ? we1 : we0;
        mem_addr  = winner_s ? addr1 : addr0;
        mem_wdata = winner_s ? wdata1 : wdata0;
      end else begin
        mem_en = 1'b0;
      end
      if (state_r == ST_RESP) begin
        done0 = ~owner_r;
        done1 = owner_r;
        if (!we_r) begin
          rdata0 = owner_r ? {DATA_W{1'b0}} : mem_rdata;
          rdata1 = owner_r ? mem_rdata : {DATA_W{1'b0}};
        end else begin
          rdata0 = {DATA_W{1'b0}};
        end
      end else begin
        done0 = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table on a round-robin MEM_LAT=2
// instance, plus sequences on fixed-priority (MEM_LAT=3) and MEM_LAT=1 copies.
module tb_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic        dn0;
    logic        dn1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        men;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        busy;
  } vec_t;

  localparam logic [31:0] Z    = 32'h0000_0000;
  localparam logic [31:0] A0   = 32'h0000_0040;
  localparam logic [31:0] A1   = 32'h0000_0080;
  localparam logic [31:0] WD   = 32'h1234_5678;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] K    = 32'hCAFE_F00D;
  localparam logic [31:0] QA0  = 32'h0000_0010;
  localparam logic [31:0] QA1  = 32'h0000_0020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, mem_init = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = Z, wdata0 = Z, addr1 = Z, wdata1 = Z;
  logic        q0 = 1'b0, q1 = 1'b0;

  logic        gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        f_g0, f_g1, f_d0, f_d1, f_en, f_we, f_busy;
  logic [31:0] f_rd0, f_rd1, f_addr, f_wdata;
  logic        l_g0, l_g1, l_d0, l_d1, l_en, l_we, l_busy;
  logic [31:0] l_rd0, l_rd1, l_addr, l_wdata;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(3), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(q0), .we0(1'b0), .addr0(QA0), .wdata0(Z),
    .req1(q1), .we1(1'b0), .addr1(QA1), .wdata1(Z),
    .gnt0(f_g0), .gnt1(f_g1), .done0(f_d0), .done1(f_d1),
    .rdata0(f_rd0), .rdata1(f_rd1),
    .mem_en(f_en), .mem_we(f_we), .mem_addr(f_addr), .mem_wdata(f_wdata),
    .mem_rdata(K), .busy(f_busy)
  );

  mem_arbiter #(.MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req0(q0), .we0(1'b0), .addr0(QA0), .wdata0(Z),
    .req1(q1), .we1(1'b0), .addr1(QA1), .wdata1(Z),
    .gnt0(l_g0), .gnt1(l_g1), .done0(l_d0), .done1(l_d1),
    .rdata0(l_rd0), .rdata1(l_rd1),
    .mem_en(l_en), .mem_we(l_we), .mem_addr(l_addr), .mem_wdata(l_wdata),
    .mem_rdata(K), .busy(l_busy)
  );

  // behavioural memory: read data follows the last command address
  logic [31:0] mem [0:255];
  logic [7:0]  rd_idx;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= Z;
      mem[16] <= BEEF;
      rd_idx  <= 8'd0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      rd_idx <= mem_addr[9:2];
    end
  end
  assign mem_rdata = mem[rd_idx];

  function automatic vec_t v(input logic rs, r0, w0, input logic [31:0] a0, d0,
                             input logic r1, w1, input logic [31:0] a1, d1,
                             input logic g0, g1, dn0, dn1, input logic [31:0] rd0, rd1,
                             input logic men, mwe, input logic [31:0] maddr, mwdata,
                             input logic bsy);
    vec_t t;
    t.rst = rs; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.dn0 = dn0; t.dn1 = dn1; t.rd0 = rd0; t.rd1 = rd1;
    t.men = men; t.mwe = mwe; t.maddr = maddr; t.mwdata = mwdata; t.busy = bsy;
    return t;
  endfunction

  task automatic chk(input string tag, input string fld, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s row %0d: got %h, want %h", tag, fld, row, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input int row, input vec_t e, input vec_t a);
    chk(tag, "gnt0",   row, {31'd0, a.g0},   {31'd0, e.g0});
    chk(tag, "gnt1",   row, {31'd0, a.g1},   {31'd0, e.g1});
    chk(tag, "done0",  row, {31'd0, a.dn0},  {31'd0, e.dn0});
    chk(tag, "done1",  row, {31'd0, a.dn1},  {31'd0, e.dn1});
    chk(tag, "rdata0", row, a.rd0, e.rd0);
    chk(tag, "rdata1", row, a.rd1, e.rd1);
    chk(tag, "mem_en", row, {31'd0, a.men},  {31'd0, e.men});
    chk(tag, "mem_we", row, {31'd0, a.mwe},  {31'd0, e.mwe});
    chk(tag, "mem_addr",  row, a.maddr,  e.maddr);
    chk(tag, "mem_wdata", row, a.mwdata, e.mwdata);
    chk(tag, "busy",   row, {31'd0, a.busy}, {31'd0, e.busy});
  endtask

  vec_t tbl[$];
  vec_t act_v, exp_v;

  initial begin
    // reset held with a pending read
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1,1,0,A0,Z, 0,0,Z,Z,   0,0,0,0,Z,Z,     0,0,Z,Z,   0));
    // single read of 0x40, write request raised during RESP is ignored
    tbl.push_back(v(0,1,0,A0,Z, 0,0,Z,Z,     1,0,0,0,Z,Z,     1,0,A0,Z,  1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   1));
    tbl.push_back(v(0,0,0,Z,Z,  1,1,A1,WD,   0,0,1,0,BEEF,Z,  0,0,Z,Z,   1));
    // write from port 1 at T+3, then port 0 reads it back
    tbl.push_back(v(0,0,0,Z,Z,  1,1,A1,WD,   0,1,0,0,Z,Z,     1,1,A1,WD, 1));
    tbl.push_back(v(0,1,0,A1,Z, 0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   1));
    tbl.push_back(v(0,1,0,A1,Z, 0,0,Z,Z,     0,0,0,1,Z,Z,     0,0,Z,Z,   1));
    tbl.push_back(v(0,1,0,A1,Z, 0,0,Z,Z,     1,0,0,0,Z,Z,     1,0,A1,Z,  1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,1,0,WD,Z,    0,0,Z,Z,   1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   0));
    // both ports requesting continuously from reset: 0,1,0,1,0
    tbl.push_back(v(1,1,0,A0,Z, 1,0,A1,Z,    0,0,0,0,Z,Z,     0,0,Z,Z,   0));
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 1,0,0,0,Z,Z,    1,0,A0,Z,  1));
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 0,0,0,0,Z,Z,    0,0,Z,Z,   1));
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 0,0,1,0,BEEF,Z, 0,0,Z,Z,   1));
      end else begin
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 0,1,0,0,Z,Z,    1,0,A1,Z,  1));
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 0,0,0,0,Z,Z,    0,0,Z,Z,   1));
        tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z, 0,0,0,1,Z,WD,   0,0,Z,Z,   1));
      end
    end
    tbl.push_back(v(0,1,0,A0,Z, 1,0,A1,Z,    1,0,0,0,Z,Z,     1,0,A0,Z,  1));
    // reset during WAIT drops the response and returns the pointer to port 0
    tbl.push_back(v(1,0,0,Z,Z,  1,0,A1,Z,    0,0,0,0,Z,Z,     0,0,Z,Z,   0));
    tbl.push_back(v(0,0,0,Z,Z,  1,0,A1,Z,    0,1,0,0,Z,Z,     1,0,A1,Z,  1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,1,Z,WD,    0,0,Z,Z,   1));
    tbl.push_back(v(0,0,0,Z,Z,  0,0,Z,Z,     0,0,0,0,Z,Z,     0,0,Z,Z,   0));

    @(negedge clk);
    mem_init = 1'b0;
    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst;
      req0 = tbl[r].r0; we0 = tbl[r].w0; addr0 = tbl[r].a0; wdata0 = tbl[r].d0;
      req1 = tbl[r].r1; we1 = tbl[r].w1; addr1 = tbl[r].a1; wdata1 = tbl[r].d1;
      #1;
      act_v = v(0,0,0,Z,Z,0,0,Z,Z, gnt0, gnt1, done0, done1, rdata0, rdata1,
                mem_en, mem_we, mem_addr, mem_wdata, busy);
      cmp("rr", r, tbl[r], act_v);
      @(negedge clk);
    end

    // fixed priority (MEM_LAT=3) and single-cycle latency copies, both requesting
    rst = 1'b1; q0 = 1'b1; q1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      q0 = (c < 12);
      #1;
      exp_v = v(0,0,0,Z,Z,0,0,Z,Z, (c < 12) && (c % 4 == 0), (c == 12),
                (c < 12) && (c % 4 == 3), (c == 15),
                ((c < 12) && (c % 4 == 3)) ? K : Z, (c == 15) ? K : Z,
                ((c < 12) && (c % 4 == 0)) || (c == 12), 1'b0,
                ((c < 12) && (c % 4 == 0)) ? QA0 : ((c == 12) ? QA1 : Z), Z, 1'b1);
      act_v = v(0,0,0,Z,Z,0,0,Z,Z, f_g0, f_g1, f_d0, f_d1, f_rd0, f_rd1,
                f_en, f_we, f_addr, f_wdata, f_busy);
      cmp("fixed", c, exp_v, act_v);
      if (c < 12) begin
        exp_v = v(0,0,0,Z,Z,0,0,Z,Z, (c % 4 == 0), (c % 4 == 2), (c % 4 == 1), (c % 4 == 3),
                  (c % 4 == 1) ? K : Z, (c % 4 == 3) ? K : Z, (c % 2 == 0), 1'b0,
                  (c % 4 == 0) ? QA0 : ((c % 4 == 2) ? QA1 : Z), Z, 1'b1);
      end else begin
        exp_v = v(0,0,0,Z,Z,0,0,Z,Z, 1'b0, (c % 2 == 0), 1'b0, (c % 2 == 1),
                  Z, (c % 2 == 1) ? K : Z, (c % 2 == 0), 1'b0,
                  (c % 2 == 0) ? QA1 : Z, Z, 1'b1);
      end
      act_v = v(0,0,0,Z,Z,0,0,Z,Z, l_g0, l_g1, l_d0, l_d1, l_rd0, l_rd1,
                l_en, l_we, l_addr, l_wdata, l_busy);
      cmp("lat1", c, exp_v, act_v);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
